gpc23_accum: RTL
================

Name: gpc23_accum

Overview:
- Streaming popcount-style accumulator that sits directly downstream of gpc23_3.
- Each beat carries LANES independent 5-bit groups; each group is `{src1[1:0], src0[2:0]}`.
- Each group is compressed by its own gpc23_3 instance (value = src0 bits ×1 + src1 bits ×2, range 0..7), and the lane results are summed.
- Beat sums are accumulated over a frame delimited by `in_last`; one frame total is emitted per frame over a valid/ready handshake.

Parameters:
- LANES, 4, number of gpc23_3 instances per beat (1..16).
- ACC_W, 16, accumulator and output width in bits (≥ 3+clog2(LANES)).

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous active-high reset.
- in_src0  input  3*LANES  weight-1 bits; lane k uses bits [3k+2:3k].
- in_src1  input  2*LANES  weight-2 bits; lane k uses bits [2k+1:2k].
- in_valid  input  1  beat valid.
- in_last  input  1  final beat of frame; qualified by in_valid.
- in_ready  output  1  beat accepted when in_valid && in_ready.
- out_sum  output  ACC_W  frame total modulo 2^ACC_W.
- out_ovf  output  1  frame total exceeded 2^ACC_W−1 (at least one wrap occurred).
- out_valid  output  1  out_sum/out_ovf valid.
- out_ready  input  1  consumer accepts when out_valid && out_ready.

Behaviour:
- Reset: while rst=1 at an edge, clear s1_valid, s1_last, s1_sum, acc, acc_ovf, out_valid, out_sum and out_ovf to 0.
  - in_ready is combinational and reads 1 after reset.
  - Reset mid-frame discards the partial frame and any pending output.
- Lane compression: lane k value = gpc23_3 dst (3 bits), using the existing gpc23_3 module unmodified.
  - beat_sum = sum of all lane values; width 3+clog2(LANES); max 7*LANES.
- Stage 1 (register): on accept, load s1_sum=beat_sum, s1_last=in_last, s1_valid=1.
  - stall = out_valid && !out_ready.
  - s1_fire = s1_valid && !stall.
  - in_ready = !s1_valid || !stall.
  - Stage 1 is reloaded on the same edge it fires (full throughput: one beat per cycle when not stalled).
  - If no accept and s1_fire, clear s1_valid.
- Stage 2 (accumulate), on s1_fire:
  - next = acc + s1_sum computed in ACC_W+1 bits; wrap = next[ACC_W].
  - If s1_last=0: acc <= next[ACC_W-1:0]; acc_ovf <= acc_ovf | wrap.
  - If s1_last=1: out_sum <= next[ACC_W-1:0]; out_ovf <= acc_ovf | wrap; out_valid <= 1; acc <= 0; acc_ovf <= 0.
- Output handshake:
  - out_valid clears on out_valid && out_ready unless a new s1_last fire sets it on the same edge; set has priority, so back-to-back frames are allowed.
  - out_sum/out_ovf must be stable while out_valid && !out_ready.
- Latency: last beat accepted at edge t produces out_valid=1 after edge t+1 (two-register pipeline: input reg, output reg).
- Single-beat frame (in_last on first beat): out_sum = beat_sum, out_ovf = 0 unless beat_sum alone wraps (impossible when ACC_W is legal).
- Empty frames are not representable; every frame is at least one beat.
- Backpressure: while stalled, at most one further beat is absorbed into stage 1, then in_ready=0. No beat is dropped or duplicated.
- in_src*/in_last are don't-care when in_valid=0.

Test Plan:
- Reset/idle: assert rst 2 cycles, then hold in_valid=0 → out_valid=0, out_sum=0, out_ovf=0, in_ready=1.
- Lane exhaustive: LANES=1, send all 32 values of `{src1,src0}` as single-beat frames with out_ready=1 → out_sum equals src0 popcount + 2×src1 popcount (0x1f→7), each appearing two cycles after accept.
- Multi-beat frame: LANES=4, 3 beats all-ones (28 each), last on beat 3 → out_sum=84, out_ovf=0, exactly one out_valid pulse.
- Backpressure: hold out_ready=0 after frame 1 (sum 28) while streaming frame 2 → out_sum stays 28; in_ready drops after one more beat. Release out_ready → frame 2 total correct, no beat lost.
- Overflow: ACC_W=6, LANES=4, 3 beats of 28 (84) → out_sum=20, out_ovf=1. The following frame of one beat of 5 → out_sum=5, out_ovf=0.
- Reset mid-frame: 2 beats of 28, assert rst 1 cycle, then a 1-beat frame of 3 → out_sum=3; no output for the aborted frame.

Source files
------------

// File: rtl/gpc23_accum.sv
// Frame accumulator for LANES parallel gpc23_3 (3,2)->3 compressors.
// It has a two-register pipeline: the beat-sum register, then the frame accumulator and output register.
module gpc23_3 (
    input  logic [2:0] src0,
    input  logic [1:0] src1,
    output logic [2:0] dst
);
    // Weighted count: each src0 bit counts as 1 and each src1 bit counts as 2.
    always_comb begin
        dst = {2'b00, src0[0]} + {2'b00, src0[1]} + {2'b00, src0[2]}
            + {1'b0, src1[0], 1'b0} + {1'b0, src1[1], 1'b0};
    end
endmodule

module gpc23_accum #(
    parameter int LANES = 4,
    parameter int ACC_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3*LANES-1:0]   in_src0,
    input  logic [2*LANES-1:0]   in_src1,
    input  logic                 in_valid,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic [ACC_W-1:0]     out_sum,
    output logic                 out_ovf,
    output logic                 out_valid,
    input  logic                 out_ready
);
    localparam int BW = 3 + $clog2(LANES);

    logic [2:0]       lane_dst_s [LANES];
    logic [BW-1:0]    beat_sum_s;
    logic             s1_valid_r;
    logic             s1_last_r;
    logic [BW-1:0]    s1_sum_r;
    logic [ACC_W-1:0] acc_r;
    logic             acc_ovf_r;
    logic [ACC_W:0]   next_s;
    logic             wrap_s;
    logic             stall_s;
    logic             s1_fire_s;
    logic             accept_s;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        gpc23_3 u_gpc (
            .src0 (in_src0[3*k +: 3]),
            .src1 (in_src1[2*k +: 2]),
            .dst  (lane_dst_s[k])
        );
    end

    // Add up the lane results. BW bits hold the largest possible total, 7*LANES.
    always_comb begin
        beat_sum_s = '0;
        for (int k = 0; k < LANES; k++) begin
            beat_sum_s = beat_sum_s + BW'(lane_dst_s[k]);
        end
    end

    // Handshake terms. Stage 1 may refill on the same edge it drains.
    always_comb begin
        stall_s   = out_valid && !out_ready;
        s1_fire_s = s1_valid_r && !stall_s;
        in_ready  = !s1_valid_r || !stall_s;
        accept_s  = in_valid && in_ready;
        next_s    = {1'b0, acc_r} + (ACC_W + 1)'(s1_sum_r);
        wrap_s    = next_s[ACC_W];
    end

    // Stage 1: the beat-sum register.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_last_r  <= 1'b0;
            s1_sum_r   <= '0;
        end else if (accept_s) begin
            s1_valid_r <= 1'b1;
            s1_last_r  <= in_last;
            s1_sum_r   <= beat_sum_s;
        end else if (s1_fire_s) begin
            s1_valid_r <= 1'b0;
        end
    end

    // Stage 2: the frame accumulator. It is cleared when the last beat of a frame fires.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r     <= '0;
            acc_ovf_r <= 1'b0;
        end else if (s1_fire_s) begin
            if (s1_last_r) begin
                acc_r     <= '0;
                acc_ovf_r <= 1'b0;
            end else begin
                acc_r     <= next_s[ACC_W-1:0];
                acc_ovf_r <= acc_ovf_r | wrap_s;
            end
        end
    end

    // Output register. Loading a new frame takes priority over the consumer's accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_ovf   <= 1'b0;
        end else if (s1_fire_s && s1_last_r) begin
            out_valid <= 1'b1;
            out_sum   <= next_s[ACC_W-1:0];
            out_ovf   <= acc_ovf_r | wrap_s;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule
